// File: rtl/compare_serial_if.sv
// compare_serial_if
//   Bundles the request, bit-stream and verdict signals of the bit-serial
//   magnitude comparator.
//   master : drives start, bit_valid, a_bit, b_bit; observes busy, done, led1..3
//   slave  : the comparator side (inverse directions)
//   start      request to begin a comparison
//   bit_valid  a_bit/b_bit carry the next bit pair (MSB first)
//   busy       comparison in progress
//   done       one-cycle pulse when the verdict is published
//   led1/2/3   a<b / a==b / a>b verdict, held until the next completion
interface compare_serial_if;
    logic start;
    logic bit_valid;
    logic a_bit;
    logic b_bit;
    logic busy;
    logic done;
    logic led1;
    logic led2;
    logic led3;

    modport master (
        output start, bit_valid, a_bit, b_bit,
        input  busy, done, led1, led2, led3
    );

    modport slave (
        input  start, bit_valid, a_bit, b_bit,
        output busy, done, led1, led2, led3
    );
endinterface

// File: rtl/compare_serial.sv
// compare_serial
//   Bit-serial unsigned magnitude comparator. WIDTH bit pairs arrive MSB-first
//   under bit_valid; the first differing pair decides the verdict, the rest are
//   consumed. The verdict is shown on three LEDs that hold until the next
//   comparison completes. All outputs come straight from flops.
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset (aborts a comparison, no done pulse)
//   bus    compare_serial_if.slave: start, bit_valid, a_bit, b_bit in;
//          busy, done, led1 (a<b), led2 (a==b), led3 (a>b) out
module compare_serial #(
    parameter int unsigned WIDTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    compare_serial_if.slave bus
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          lt_f, gt_f, lt_nx, gt_nx;
    logic          busy_q, done_q;
    logic          led1_q, led2_q, led3_q;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        lt_nx    = lt_f;
        gt_nx    = gt_f;
        case (state)
            IDLE: begin
                lt_nx = 1'b0;
                gt_nx = 1'b0;
                if (bus.start) begin
                    state_nx = RUN;
                    cnt_nx   = CW'(WIDTH);
                end
            end
            RUN: begin
                if (bus.bit_valid) begin
                    // Flags are sticky: only the first differing pair counts.
                    if (!(lt_f || gt_f)) begin
                        lt_nx = ~bus.a_bit & bus.b_bit;
                        gt_nx = bus.a_bit & ~bus.b_bit;
                    end
                    cnt_nx = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            lt_f   <= 1'b0;
            gt_f   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            led1_q <= 1'b0;
            led2_q <= 1'b0;
            led3_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            lt_f   <= lt_nx;
            gt_f   <= gt_nx;
            // Status flops follow the next state so they line up with it.
            busy_q <= (state_nx == RUN);
            done_q <= (state_nx == DONE);
            // Loading from the next-flag values lets the last bit pair still
            // decide while the LEDs change exactly in the DONE cycle.
            if (state == RUN && state_nx == DONE) begin
                led1_q <= lt_nx;
                led2_q <= ~(lt_nx | gt_nx);
                led3_q <= gt_nx;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.led1 = led1_q;
    assign bus.led2 = led2_q;
    assign bus.led3 = led3_q;

endmodule

// File: tb/tb_compare_serial.sv
// tb_compare_serial
//   Drives an 8-bit and a 1-bit comparator. Drivers push the expected verdict
//   (from plain integer comparison) and publish cycle into queues; independent
//   monitors pop on every done pulse and also track busy and LED hold.
module tb_compare_serial;

    typedef struct {
        logic        lt;
        logic        eq;
        logic        gt;
        int unsigned dc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int          tests = 0;
    int          failed = 0;
    bit          mon_en = 1'b0;

    exp_t        q8[$];
    exp_t        q1[$];
    logic [2:0]  held8 = '0;
    logic [2:0]  held1 = '0;
    logic        exp_busy8 = 1'b0;
    logic        exp_busy1 = 1'b0;

    compare_serial_if b8();
    compare_serial_if b1();

    compare_serial #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    compare_serial #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s @cyc %0d: actual %0h required %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (b8.done === 1'b1) begin
                if (q8.size() == 0) begin
                    chk("done8_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    chk("leds8", {b8.led1, b8.led2, b8.led3}, {e.lt, e.eq, e.gt});
                    chk("done8_cycle", cyc, e.dc);
                    held8 = {e.lt, e.eq, e.gt};
                end
            end else begin
                chk("leds8_hold", {b8.led1, b8.led2, b8.led3}, held8);
                if (q8.size() > 0 && cyc > q8[0].dc) begin
                    chk("done8_missing", cyc, q8[0].dc);
                    void'(q8.pop_front());
                end
            end
            chk("busy8", b8.busy, exp_busy8);
        end
    end

    // Monitor for the 1-bit instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (b1.done === 1'b1) begin
                if (q1.size() == 0) begin
                    chk("done1_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("leds1", {b1.led1, b1.led2, b1.led3}, {e.lt, e.eq, e.gt});
                    chk("done1_cycle", cyc, e.dc);
                    held1 = {e.lt, e.eq, e.gt};
                end
            end else begin
                chk("leds1_hold", {b1.led1, b1.led2, b1.led3}, held1);
                if (q1.size() > 0 && cyc > q1[0].dc) begin
                    chk("done1_missing", cyc, q1[0].dc);
                    void'(q1.pop_front());
                end
            end
            chk("busy1", b1.busy, exp_busy1);
        end
    end

    // One 8-bit comparison; optional bit_valid gap after bit index gap_at
    // (with a stray start in its first cycle) and optional start in DONE.
    task automatic compare8(input logic [7:0] a, input logic [7:0] b,
                            input int gap_at, input int gap_len, input bit start_in_done);
        exp_t e;
        tick;
        b8.start     = 1'b1;
        b8.bit_valid = 1'($urandom_range(0, 1));
        b8.a_bit     = 1'($urandom_range(0, 1));
        b8.b_bit     = 1'($urandom_range(0, 1));
        exp_busy8    = 1'b0;
        e.lt = (a < b);
        e.eq = (a == b);
        e.gt = (a > b);
        e.dc = cyc + 9 + gap_len;
        q8.push_back(e);
        for (int i = 7; i >= 0; i--) begin
            tick;
            b8.start     = 1'b0;
            exp_busy8    = 1'b1;
            b8.bit_valid = 1'b1;
            b8.a_bit     = a[i];
            b8.b_bit     = b[i];
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    tick;
                    b8.bit_valid = 1'b0;
                    b8.a_bit     = 1'($urandom_range(0, 1));
                    b8.b_bit     = 1'($urandom_range(0, 1));
                    b8.start     = (g == 0);
                end
            end
        end
        tick;
        b8.start     = start_in_done;
        b8.bit_valid = 1'($urandom_range(0, 1));
        exp_busy8    = 1'b0;
    endtask

    task automatic compare1(input logic a, input logic b, input bit start_in_done);
        exp_t e;
        tick;
        b1.start     = 1'b1;
        b1.bit_valid = 1'b0;
        exp_busy1    = 1'b0;
        e.lt = (a < b);
        e.eq = (a == b);
        e.gt = (a > b);
        e.dc = cyc + 2;
        q1.push_back(e);
        tick;
        b1.start     = 1'b0;
        b1.bit_valid = 1'b1;
        b1.a_bit     = a;
        b1.b_bit     = b;
        exp_busy1    = 1'b1;
        tick;
        b1.bit_valid = 1'b0;
        b1.start     = start_in_done;
        exp_busy1    = 1'b0;
    endtask

    initial begin
        logic [7:0] ra, rb;
        b8.start = 1'b0; b8.bit_valid = 1'b0; b8.a_bit = 1'b0; b8.b_bit = 1'b0;
        b1.start = 1'b0; b1.bit_valid = 1'b0; b1.a_bit = 1'b0; b1.b_bit = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick;
        @(negedge clk);
        chk("rst_busy8", b8.busy, 0);
        chk("rst_done8", b8.done, 0);
        chk("rst_leds8", {b8.led1, b8.led2, b8.led3}, 0);
        chk("rst_busy1", b1.busy, 0);
        chk("rst_done1", b1.done, 0);
        chk("rst_leds1", {b1.led1, b1.led2, b1.led3}, 0);
        tick;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Directed cases.
        compare8(8'hA5, 8'hA5, -1, 0, 1'b0);
        compare8(8'h80, 8'h7F, -1, 0, 1'b1);
        compare8(8'h12, 8'h13, -1, 0, 1'b0);
        compare8(8'h3C, 8'h3D, 4, 3, 1'b1);
        tick;
        b8.start = 1'b0;

        // Reset in the middle of a comparison.
        tick;
        b8.start = 1'b1;
        b8.bit_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            b8.start = 1'b0;
            exp_busy8 = 1'b1;
            b8.bit_valid = 1'b1;
            b8.a_bit = 1'b1;
            b8.b_bit = 1'b0;
        end
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        b8.bit_valid = 1'b0;
        exp_busy8 = 1'b0;
        held8 = '0;
        held1 = '0;
        @(negedge clk);
        chk("abort_busy8", b8.busy, 0);
        chk("abort_done8", b8.done, 0);
        chk("abort_leds8", {b8.led1, b8.led2, b8.led3}, 0);
        compare8(8'h01, 8'h00, -1, 0, 1'b0);

        // Width-1 instance, back-to-back.
        compare1(1'b1, 1'b0, 1'b0);
        compare1(1'b0, 1'b1, 1'b1);
        compare1(1'b1, 1'b1, 1'b0);
        compare1(1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 6; n++)
            compare1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        tick;
        b1.start = 1'b0;

        // Randomised 8-bit comparisons, some equal, some one bit apart.
        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom);
            case ($urandom_range(0, 2))
                0: rb = ra;
                1: rb = ra ^ (8'd1 << $urandom_range(0, 7));
                default: rb = 8'($urandom);
            endcase
            compare8(ra, rb, int'($urandom_range(1, 7)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)));
        end
        tick;
        b8.start = 1'b0;
        repeat (5) tick;
        @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q1_drained", q1.size(), 0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
